// File: rtl/sram_drvr.sv
// sram_drvr: pin-level driver for a 256Kx16 asynchronous SRAM.
// Registers one command per clock onto the pins; read data lands two clocks after the command.
module sram_drvr #(
    parameter int P_SRAM_ADDR_W = 18,
    parameter int P_SRAM_DATA_W = 16,
    parameter int P_CNTR_W      = 16
) (
    input  logic                     clk_ir,
    input  logic                     rst_ih,
    input  logic                     sram_wr_en_ih,
    input  logic                     sram_rd_en_ih,
    input  logic [P_SRAM_ADDR_W-1:0] sram_addr_id,
    input  logic [P_SRAM_DATA_W-1:0] sram_wr_data_id,
    output logic [P_SRAM_DATA_W-1:0] sram_rd_data_od,
    output logic                     coll_err_oh,
    input  logic                     coll_err_clr_ih,
    output logic [P_CNTR_W-1:0]      wr_cnt_od,
    output logic [P_CNTR_W-1:0]      rd_cnt_od,
    output logic [P_SRAM_ADDR_W-1:0] sram_addr_od,
    inout  wire  [P_SRAM_DATA_W-1:0] sram_dq_iod,
    output logic                     sram_ce_n_ol,
    output logic                     sram_oe_n_ol,
    output logic                     sram_we_n_ol,
    output logic                     sram_ub_n_ol,
    output logic                     sram_lb_n_ol
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic w_ce_n;
    logic w_oe_n;
    logic w_we_n;
    logic w_bs_n;
    logic w_dq_oe;
    logic w_coll;

    logic                     r_ce_n;
    logic                     r_oe_n;
    logic                     r_we_n;
    logic                     r_bs_n;
    logic                     r_dq_oe;
    logic [P_SRAM_ADDR_W-1:0] r_addr;
    logic [P_SRAM_DATA_W-1:0] r_wr_data;
    logic [P_SRAM_DATA_W-1:0] r_rd_data;
    logic                     r_coll;
    logic [P_CNTR_W-1:0]      r_wr_cnt;
    logic [P_CNTR_W-1:0]      r_rd_cnt;

    // A write wins over a read when both are requested together.
    assign w_coll = sram_wr_en_ih & sram_rd_en_ih;

    // Next state and next pin levels, decided from this cycle's command.
    always_comb begin
        w_next  = S_IDLE;
        w_ce_n  = 1'b1;
        w_oe_n  = 1'b1;
        w_we_n  = 1'b1;
        w_bs_n  = 1'b1;
        w_dq_oe = 1'b0;
        if (sram_wr_en_ih) begin
            w_next  = S_WR;
            w_ce_n  = 1'b0;
            w_we_n  = 1'b0;
            w_bs_n  = 1'b0;
            w_dq_oe = 1'b1;
        end else if (sram_rd_en_ih) begin
            w_next  = S_RD;
            w_ce_n  = 1'b0;
            w_oe_n  = 1'b0;
            w_bs_n  = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk_ir) begin
        if (rst_ih) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Strobes and bus direction registered so the pins change glitch-free on the edge.
    always_ff @(posedge clk_ir) begin
        if (rst_ih) begin
            r_ce_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_we_n  <= 1'b1;
            r_bs_n  <= 1'b1;
            r_dq_oe <= 1'b0;
        end else begin
            r_ce_n  <= w_ce_n;
            r_oe_n  <= w_oe_n;
            r_we_n  <= w_we_n;
            r_bs_n  <= w_bs_n;
            r_dq_oe <= w_dq_oe;
        end
    end

    // Address follows every command and holds through idle cycles.
    always_ff @(posedge clk_ir) begin
        if (rst_ih) begin
            r_addr <= '0;
        end else if (w_next != S_IDLE) begin
            r_addr <= sram_addr_id;
        end
    end

    // Write data is registered alongside the address for the write cycle.
    always_ff @(posedge clk_ir) begin
        if (rst_ih) begin
            r_wr_data <= '0;
        end else if (w_next == S_WR) begin
            r_wr_data <= sram_wr_data_id;
        end
    end

    // Read data captured on the edge leaving a read cycle; reset drops any pending capture.
    always_ff @(posedge clk_ir) begin
        if (rst_ih) begin
            r_rd_data <= '0;
        end else if (r_state == S_RD) begin
            r_rd_data <= sram_dq_iod;
        end
    end

    // Sticky collision flag; a new collision outranks a clear in the same cycle.
    always_ff @(posedge clk_ir) begin
        if (rst_ih) begin
            r_coll <= 1'b0;
        end else if (w_coll) begin
            r_coll <= 1'b1;
        end else if (coll_err_clr_ih) begin
            r_coll <= 1'b0;
        end
    end

    // Write counter, saturating at all-ones.
    always_ff @(posedge clk_ir) begin
        if (rst_ih) begin
            r_wr_cnt <= '0;
        end else if (w_next == S_WR && r_wr_cnt != '1) begin
            r_wr_cnt <= r_wr_cnt + P_CNTR_W'(1);
        end
    end

    // Read counter, saturating at all-ones.
    always_ff @(posedge clk_ir) begin
        if (rst_ih) begin
            r_rd_cnt <= '0;
        end else if (w_next == S_RD && r_rd_cnt != '1) begin
            r_rd_cnt <= r_rd_cnt + P_CNTR_W'(1);
        end
    end

    assign sram_dq_iod     = r_dq_oe ? r_wr_data : {P_SRAM_DATA_W{1'bz}};
    assign sram_addr_od    = r_addr;
    assign sram_ce_n_ol    = r_ce_n;
    assign sram_oe_n_ol    = r_oe_n;
    assign sram_we_n_ol    = r_we_n;
    assign sram_ub_n_ol    = r_bs_n;
    assign sram_lb_n_ol    = r_bs_n;
    assign sram_rd_data_od = r_rd_data;
    assign coll_err_oh     = r_coll;
    assign wr_cnt_od       = r_wr_cnt;
    assign rd_cnt_od       = r_rd_cnt;

endmodule
